mc_ctrl_fsm: RTL
================

// Module: mc_ctrl_fsm
// PURPOSE
//  Multi-cycle successor to the single-cycle RV32I control decoder. Latches the
//  instruction, decodes it once, then sequences FETCH/DECODE/EXEC/MEM/WB with
//  req/ready handshakes to instruction and data memory.
//  Sits between the IR/PC datapath and the ALU, register file, EXT, NPC and DM.
//  Adds bus timeouts, an illegal-instruction trap and a retired-instruction counter.
// PARAMETERS
//  ALUOP_W    5   width of ALUOp (nop=0,lui=1,auipc=2,add=3,sub=4,bne=5,blt=6,bge=7,bltu=8,
//                 bgeu=9,slt=10,sltu=11,xor=12,or=13,and=14,sll=15,srl=16,sra=17)
//  TIMEOUT    16  max cycles waiting for *_ready before a bus-error trap (>=1)
//  RET_W      32  width of the retired-instruction counter
// PORTS
//  clk          in   1        clock, rising edge
//  rstn         in   1        asynchronous active-low reset
//  instr        in   32       instruction word from IMEM, valid when imem_ready=1
//  Zero         in   1        ALU condition result (1 = branch condition true)
//  imem_ready   in   1        IMEM accepts or completes the fetch
//  dmem_ready   in   1        DMEM completes the load or store
//  imem_req     out  1        fetch request
//  dmem_req     out  1        data access request
//  IRWrite      out  1        latch instr into IR
//  PCWrite      out  1        update PC using NPCOp (one pulse per instruction)
//  RegWrite     out  1        register-file write strobe
//  MemWrite     out  1        DM write (qualifies dmem_req)
//  MemRead      out  1        DM read (qualifies dmem_req)
//  EXTOp        out  6        one-hot: [5]shamt [4]I [3]S [2]B [1]U [0]J
//  ALUOp        out  ALUOP_W  ALU operation (encoding above)
//  ALUSrc       out  1        ALU B from immediate
//  NPCOp        out  3        000 +4, 001 branch, 010 jal, 100 jalr
//  WDSel        out  2        00 ALU, 01 MEM, 10 PC+4
//  DMType       out  3        000 w, 001 h, 010 b, 011 hu, 100 bu
//  trap         out  1        sticky: illegal instruction or bus timeout
//  trap_cause   out  2        01 illegal, 10 imem timeout, 11 dmem timeout
//  retired      out  RET_W    count of instructions completed
// BEHAVIOUR
//  Reset (async, rstn=0): state=FETCH; all strobes, req, trap=0; trap_cause=0;
//   retired=0; EXTOp/ALUOp/NPCOp/WDSel/DMType=0. Reset mid-access aborts it, no PCWrite.
//  States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
//  FETCH: imem_req=1 until imem_ready. On ready: IRWrite=1 for that cycle -> DECODE.
//  DECODE (1 cycle): decode the IR opcode/funct3/funct7 per RV32I into registered controls.
//   EXTOp, ALUOp, ALUSrc, WDSel and DMType hold steady from EXEC to the instruction's end.
//   Unknown opcode/funct -> TRAP with cause 01.
//  EXEC:
//   R/I-ALU, lui, auipc -> WB.
//   load/store -> MEM.
//   branch: PCWrite=1, NPCOp=001 if Zero else 000, retire -> FETCH.
//   jal/jalr: RegWrite=1, WDSel=10, PCWrite=1, NPCOp=010/100, retire -> FETCH.
//  MEM: dmem_req=1, with MemRead (load) or MemWrite (store), until dmem_ready.
//   On ready: a store sets PCWrite=1, NPCOp=000, retires -> FETCH; a load goes to WB.
//  WB: RegWrite=1, PCWrite=1, NPCOp=000, retire -> FETCH.
//  Latency (zero wait): branch/jal/jalr 3, ALU/store 4, load 5 cycles.
//   Each wait cycle adds 1.
//  Timeout: a counter clears on entry to FETCH or MEM and increments each cycle
//   that ready=0. At TIMEOUT it enters TRAP with cause 10/11; the access is not completed.
//  TRAP: all strobes and req are 0. Stays until reset. trap and trap_cause hold.
//  retired increments by 1 on each PCWrite cycle and wraps modulo 2^RET_W.
//  RegWrite is forced 0 when rd=0; PCWrite still fires.
//  Strobes are combinational from state plus the registered decode. req stays high
//   while waiting, regardless of ready.
// TESTING
//  - add x3,x1,x2, ready tied 1 -> IRWrite@c1, RegWrite+PCWrite@c4,
//    ALUOp=3, WDSel=00, retired=1.
//  - lw with dmem_ready delayed 3 cycles -> MemRead held 4 cycles,
//    RegWrite with WDSel=01 in WB, total 8 cycles.
//  - beq with Zero=1, then Zero=0 -> NPCOp=001 then 000, PCWrite once each, no RegWrite.
//  - imem_ready held 0 with TIMEOUT=16 -> trap=1, trap_cause=10 after 16 cycles;
//    no strobes afterwards.
//  - opcode 7'b1111111 -> trap_cause=01 after DECODE;
//    rstn pulse mid-MEM -> FETCH, retired=0.
//  - sh and lbu -> DMType 001 and 100; EXTOp 001000 and 010000.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with IMEM/DMEM
// handshakes, bus timeouts, illegal-instruction trap and retired-instruction count.
module mc_ctrl_fsm #(
    parameter int unsigned ALUOP_W = 5,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned RET_W   = 32
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [31:0]        instr,
    input  logic               Zero,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    output logic               imem_req,
    output logic               dmem_req,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic               MemRead,
    output logic [5:0]         EXTOp,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               ALUSrc,
    output logic [2:0]         NPCOp,
    output logic [1:0]         WDSel,
    output logic [2:0]         DMType,
    output logic               trap,
    output logic [1:0]         trap_cause,
    output logic [RET_W-1:0]   retired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [5:0] EXT_SH = 6'b100000;
    localparam logic [5:0] EXT_I  = 6'b010000;
    localparam logic [5:0] EXT_S  = 6'b001000;
    localparam logic [5:0] EXT_B  = 6'b000100;
    localparam logic [5:0] EXT_U  = 6'b000010;
    localparam logic [5:0] EXT_J  = 6'b000001;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_e;
    typedef enum logic [2:0] {K_ALU, K_LOAD, K_STORE, K_BRANCH, K_JAL, K_JALR} kind_e;
    typedef enum logic [4:0] {
        ALU_NOP, ALU_LUI, ALU_AUIPC, ALU_ADD, ALU_SUB, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU,
        ALU_BGEU, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_OR, ALU_AND, ALU_SLL, ALU_SRL, ALU_SRA
    } alu_e;

    state_e           state, state_d;
    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_hit, waiting;
    logic [1:0]       cause_d;

    logic [6:0] ir_op, ir_f7;
    logic [2:0] ir_f3;
    logic [4:0] ir_rd;
    logic       unused_rs;

    kind_e      d_kind, kind_q;
    alu_e       d_alu, alu_q;
    logic [5:0] d_ext;
    logic       d_src, d_illegal, rd_nz;
    logic [1:0] d_wd;
    logic [2:0] d_dm;

    // Register-source fields are consumed by the datapath, not by control.
    assign unused_rs = ^instr[24:15];

    always_comb begin
        d_kind    = K_ALU;
        d_alu     = ALU_NOP;
        d_ext     = '0;
        d_src     = 1'b0;
        d_wd      = 2'b00;
        d_dm      = 3'b000;
        d_illegal = 1'b0;
        case (ir_op)
            OP_R: begin
                case ({ir_f7, ir_f3})
                    {7'h00, 3'b000}: d_alu = ALU_ADD;
                    {7'h20, 3'b000}: d_alu = ALU_SUB;
                    {7'h00, 3'b001}: d_alu = ALU_SLL;
                    {7'h00, 3'b010}: d_alu = ALU_SLT;
                    {7'h00, 3'b011}: d_alu = ALU_SLTU;
                    {7'h00, 3'b100}: d_alu = ALU_XOR;
                    {7'h00, 3'b101}: d_alu = ALU_SRL;
                    {7'h20, 3'b101}: d_alu = ALU_SRA;
                    {7'h00, 3'b110}: d_alu = ALU_OR;
                    {7'h00, 3'b111}: d_alu = ALU_AND;
                    default:         d_illegal = 1'b1;
                endcase
            end
            OP_I: begin
                d_src = 1'b1;
                d_ext = EXT_I;
                case (ir_f3)
                    3'b000: d_alu = ALU_ADD;
                    3'b010: d_alu = ALU_SLT;
                    3'b011: d_alu = ALU_SLTU;
                    3'b100: d_alu = ALU_XOR;
                    3'b110: d_alu = ALU_OR;
                    3'b111: d_alu = ALU_AND;
                    3'b001: begin
                        d_ext = EXT_SH;
                        if (ir_f7 == 7'h00) d_alu = ALU_SLL;
                        else                d_illegal = 1'b1;
                    end
                    default: begin
                        d_ext = EXT_SH;
                        if (ir_f7 == 7'h00)      d_alu = ALU_SRL;
                        else if (ir_f7 == 7'h20) d_alu = ALU_SRA;
                        else                     d_illegal = 1'b1;
                    end
                endcase
            end
            OP_LOAD: begin
                d_kind = K_LOAD;
                d_src  = 1'b1;
                d_ext  = EXT_I;
                d_alu  = ALU_ADD;
                d_wd   = 2'b01;
                case (ir_f3)
                    3'b000:  d_dm = 3'b010;
                    3'b001:  d_dm = 3'b001;
                    3'b010:  d_dm = 3'b000;
                    3'b100:  d_dm = 3'b100;
                    3'b101:  d_dm = 3'b011;
                    default: d_illegal = 1'b1;
                endcase
            end
            OP_STORE: begin
                d_kind = K_STORE;
                d_src  = 1'b1;
                d_ext  = EXT_S;
                d_alu  = ALU_ADD;
                case (ir_f3)
                    3'b000:  d_dm = 3'b010;
                    3'b001:  d_dm = 3'b001;
                    3'b010:  d_dm = 3'b000;
                    default: d_illegal = 1'b1;
                endcase
            end
            OP_BRANCH: begin
                d_kind = K_BRANCH;
                d_ext  = EXT_B;
                case (ir_f3)
                    3'b000:  d_alu = ALU_SUB;
                    3'b001:  d_alu = ALU_BNE;
                    3'b100:  d_alu = ALU_BLT;
                    3'b101:  d_alu = ALU_BGE;
                    3'b110:  d_alu = ALU_BLTU;
                    3'b111:  d_alu = ALU_BGEU;
                    default: d_illegal = 1'b1;
                endcase
            end
            OP_LUI: begin
                d_alu = ALU_LUI;
                d_ext = EXT_U;
                d_src = 1'b1;
            end
            OP_AUIPC: begin
                d_alu = ALU_AUIPC;
                d_ext = EXT_U;
                d_src = 1'b1;
            end
            OP_JAL: begin
                d_kind = K_JAL;
                d_ext  = EXT_J;
                d_wd   = 2'b10;
            end
            OP_JALR: begin
                d_kind    = K_JALR;
                d_ext     = EXT_I;
                d_src     = 1'b1;
                d_alu     = ALU_ADD;
                d_wd      = 2'b10;
                d_illegal = (ir_f3 != 3'b000);
            end
            default: d_illegal = 1'b1;
        endcase
    end

    assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT - 1));
    assign waiting = ((state == FETCH) && !imem_ready) || ((state == MEM) && !dmem_ready);

    // Strobes are held low while rstn is asserted even though state already reads FETCH.
    always_comb begin
        state_d  = state;
        cause_d  = 2'b00;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        RegWrite = 1'b0;
        MemWrite = 1'b0;
        MemRead  = 1'b0;
        NPCOp    = 3'b000;
        if (rstn) begin
            case (state)
                FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        IRWrite = 1'b1;
                        state_d = DECODE;
                    end else if (tmo_hit) begin
                        state_d = TRAP;
                        cause_d = 2'b10;
                    end
                end
                DECODE: begin
                    state_d = d_illegal ? TRAP : EXEC;
                    cause_d = 2'b01;
                end
                EXEC: begin
                    case (kind_q)
                        K_LOAD, K_STORE: state_d = MEM;
                        K_BRANCH: begin
                            PCWrite = 1'b1;
                            NPCOp   = Zero ? 3'b001 : 3'b000;
                            state_d = FETCH;
                        end
                        K_JAL, K_JALR: begin
                            RegWrite = rd_nz;
                            PCWrite  = 1'b1;
                            NPCOp    = (kind_q == K_JAL) ? 3'b010 : 3'b100;
                            state_d  = FETCH;
                        end
                        default: state_d = WB;
                    endcase
                end
                MEM: begin
                    dmem_req = 1'b1;
                    MemRead  = (kind_q == K_LOAD);
                    MemWrite = (kind_q == K_STORE);
                    if (dmem_ready) begin
                        if (kind_q == K_LOAD) begin
                            state_d = WB;
                        end else begin
                            PCWrite = 1'b1;
                            state_d = FETCH;
                        end
                    end else if (tmo_hit) begin
                        state_d = TRAP;
                        cause_d = 2'b11;
                    end
                end
                WB: begin
                    RegWrite = rd_nz;
                    PCWrite  = 1'b1;
                    state_d  = FETCH;
                end
                default: state_d = TRAP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= FETCH;
            tmo_cnt    <= '0;
            trap       <= 1'b0;
            trap_cause <= '0;
            retired    <= '0;
        end else begin
            state <= state_d;
            if (state_d != state) tmo_cnt <= '0;
            else if (waiting)     tmo_cnt <= tmo_cnt + CNT_W'(1);
            if ((state_d == TRAP) && (state != TRAP)) begin
                trap       <= 1'b1;
                trap_cause <= cause_d;
            end
            if (PCWrite) retired <= retired + RET_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ir_op  <= '0;
            ir_f3  <= '0;
            ir_f7  <= '0;
            ir_rd  <= '0;
            kind_q <= K_ALU;
            alu_q  <= ALU_NOP;
            EXTOp  <= '0;
            ALUSrc <= 1'b0;
            WDSel  <= '0;
            DMType <= '0;
            rd_nz  <= 1'b0;
        end else begin
            if (IRWrite) begin
                ir_op <= instr[6:0];
                ir_rd <= instr[11:7];
                ir_f3 <= instr[14:12];
                ir_f7 <= instr[31:25];
            end
            if ((state == DECODE) && !d_illegal) begin
                kind_q <= d_kind;
                alu_q  <= d_alu;
                EXTOp  <= d_ext;
                ALUSrc <= d_src;
                WDSel  <= d_wd;
                DMType <= d_dm;
                rd_nz  <= (ir_rd != 5'd0);
            end
        end
    end

    assign ALUOp = ALUOP_W'(alu_q);

endmodule
